online_add_sequencer: RTL and testbench

Sequences one radix-2 signed-digit on-line adder for the Newton datapath.
- Accepts two N-digit signed-digit operand words.
- Clears the adder's unreset internal state.
- Streams operands MSD-first with the adder enable and drains its online delay.
- Collects N+1 result digits into a parallel word.
- Offers the result on a valid/ready handshake.

---
 rtl/online_pkg.sv | 43 ++++
 rtl/sd_shift_reg.sv | 32 +++
 rtl/online_add_sequencer.sv | 150 +++++++++++++++
 tb/tb_online_add_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/online_pkg.sv
// rtl/online_pkg.sv - shared digit codes, state encoding and signed-digit helpers
// Purpose : common definitions for the on-line adder sequencer and its sub-module.
// Contents: DIG_POS/DIG_NEG/DIG_ZERO digit codes, seq_state_e FSM states,
//           sd_clean (maps the unused 11 code to zero), sd_digit, sd_value.
package online_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_STREAM,
        ST_DRAIN,
        ST_HOLD
    } seq_state_e;

    // 11 is not a legal digit; treat it as zero wherever a digit is taken in.
    function automatic logic [1:0] sd_clean(input logic [1:0] d);
        return (d == 2'b11) ? DIG_ZERO : d;
    endfunction

    function automatic int sd_digit(input logic [1:0] d);
        if (d == DIG_POS) return 1;
        if (d == DIG_NEG) return -1;
        return 0;
    endfunction

    // Value of an ndig-digit word, MSD in the top two used bits, scaled so that
    // the least significant digit has weight 1 (i.e. value * 2^(weight of LSD)).
    function automatic int sd_value(input logic [63:0] word, input int ndig);
        int acc;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < ndig) begin
                acc = acc * 2 + sd_digit(word[2*(ndig-1-i) +: 2]);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sd_shift_reg.sv
// rtl/sd_shift_reg.sv - parallel-load MSD-first signed-digit shift register
// Purpose : holds one N-digit operand and presents its current leading digit.
// Ports   : clk, rst_n (async active-low), load_i/word_i (parallel load, wins
//           over shift), shift_i (advance one digit), msd_o (current digit).
module sd_shift_reg
    import online_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic [2*N-1:0] word_i,
    input  logic           shift_i,
    output logic [1:0]     msd_o
);

    logic [2*N-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= word_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[2*N-3:0], DIG_ZERO};
        end
    end

    assign msd_o = sr_q[2*N-1 -: 2];

endmodule

// File: rtl/online_add_sequencer.sv
// rtl/online_add_sequencer.sv - sequencer for a radix-2 signed-digit on-line adder
// Purpose : loads two N-digit operands, flushes the adder's unreset state with
//           zeros, streams digits MSD-first, drains the online delay, collects
//           N+1 result digits and offers them on a valid/ready handshake.
// Ports   : clk, rst_n (async active-low); start/x_word/y_word request;
//           pause freezes sequencing; busy; add_en/add_x/add_y/add_z adder
//           interface; res_word/res_valid/res_ready result handshake.
module online_add_sequencer
    import online_pkg::*;
#(
    parameter int N     = 8,
    parameter int DELTA = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*N-1:0]     x_word,
    input  logic [2*N-1:0]     y_word,
    input  logic               pause,
    output logic               busy,
    output logic               add_en,
    output logic [1:0]         add_x,
    output logic [1:0]         add_y,
    input  logic [1:0]         add_z,
    output logic [2*(N+1)-1:0] res_word,
    output logic               res_valid,
    input  logic               res_ready
);

    localparam int CW = $clog2(N + 2*DELTA + 1);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(DELTA - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(N + DELTA - 1);
    localparam logic [CW-1:0] CAP_FIRST   = CW'(DELTA - 1);

    seq_state_e           state_q;
    logic [CW-1:0]        cnt_q;     // FLUSH cycle count, then digit index s
    logic                 busy_q;
    logic                 res_valid_q;
    logic [2*(N+1)-1:0]   res_q;

    logic                 seq_phase;
    logic                 active;
    logic                 load;
    logic                 shift;
    logic                 capture;
    logic [1:0]           x_msd;
    logic [1:0]           y_msd;

    assign seq_phase = (state_q == ST_FLUSH) || (state_q == ST_STREAM) ||
                       (state_q == ST_DRAIN);
    assign active    = seq_phase && !pause;
    assign load      = (state_q == ST_IDLE) && start;
    assign shift     = active && (state_q == ST_STREAM);
    // cnt_q carries on from STREAM into DRAIN, so it is the digit index s here.
    assign capture   = active && (state_q != ST_FLUSH) && (cnt_q >= CAP_FIRST);

    sd_shift_reg #(.N(N)) u_x_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .word_i  (x_word),
        .shift_i (shift),
        .msd_o   (x_msd)
    );

    sd_shift_reg #(.N(N)) u_y_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .word_i  (y_word),
        .shift_i (shift),
        .msd_o   (y_msd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (capture) begin
                res_q <= {res_q[2*N-1:0], sd_clean(add_z)};
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        res_q   <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (!pause) begin
                        if (cnt_q == FLUSH_LAST) begin
                            state_q <= ST_STREAM;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (!pause) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == STREAM_LAST) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pause) begin
                        if (cnt_q == DRAIN_LAST) begin
                            state_q     <= ST_HOLD;
                            cnt_q       <= '0;
                            res_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_word  = res_q;
    // Digits only come from registered state, so they hold while paused.
    assign add_en    = active;
    assign add_x     = (state_q == ST_STREAM) ? sd_clean(x_msd) : DIG_ZERO;
    assign add_y     = (state_q == ST_STREAM) ? sd_clean(y_msd) : DIG_ZERO;

endmodule

// File: tb/tb_online_add_sequencer.sv
// tb/tb_online_add_sequencer.sv - self-checking bench for online_add_sequencer
module tb_online_add_sequencer;
    import online_pkg::*;

    localparam int N     = 8;
    localparam int DELTA = 2;
    localparam int BASE_LAT = 2*DELTA + N + 1;
    localparam int ACTIVE_CYC = 2*DELTA + N;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [2*N-1:0]     x_word;
    logic [2*N-1:0]     y_word;
    logic               pause;
    logic               busy;
    logic               add_en;
    logic [1:0]         add_x;
    logic [1:0]         add_y;
    logic [1:0]         add_z;
    logic [2*(N+1)-1:0] res_word;
    logic               res_valid;
    logic               res_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    online_add_sequencer #(.N(N), .DELTA(DELTA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_word    (x_word),
        .y_word    (y_word),
        .pause     (pause),
        .busy      (busy),
        .add_en    (add_en),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_z     (add_z),
        .res_word  (res_word),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    // Behavioural radix-2 on-line adder, delay 2, no reset (starts dirty).
    // p = x+y per position is split into 2t+w with one position of lookahead,
    // and z_k = w_k + t_{k+1}.
    int p0_m = 2;
    int p1_m = -2;

    function automatic int tw_t(input int p, input int pn);
        if (p == 2)  return 1;
        if (p == -2) return -1;
        if (p == 1)  return (pn >= 0) ? 1 : 0;
        if (p == -1) return (pn >= 0) ? 0 : -1;
        return 0;
    endfunction

    function automatic int tw_w(input int p, input int pn);
        if (p == 1)  return (pn >= 0) ? -1 : 1;
        if (p == -1) return (pn >= 0) ? -1 : 1;
        return 0;
    endfunction

    always_comb begin
        int pn;
        int z;
        pn = sd_digit(add_x) + sd_digit(add_y);
        z  = tw_w(p0_m, p1_m) + tw_t(p1_m, pn);
        add_z = (z == 1) ? DIG_POS : ((z == -1) ? DIG_NEG : DIG_ZERO);
    end

    always @(posedge clk) begin
        if (add_en) begin
            p0_m <= p1_m;
            p1_m <= sd_digit(add_x) + sd_digit(add_y);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2*N-1:0] rand_word();
        logic [2*N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
                0:       w[2*i +: 2] = DIG_ZERO;
                1:       w[2*i +: 2] = DIG_POS;
                default: w[2*i +: 2] = DIG_NEG;
            endcase
        end
        return w;
    endfunction

    function automatic int ref_sum(input logic [2*N-1:0] x, input logic [2*N-1:0] y);
        return sd_value(64'(x), N) + sd_value(64'(y), N);
    endfunction

    // Expected latency: the op needs ACTIVE_CYC unpaused cycles starting at cycle 1.
    function automatic int ref_lat(input logic [63:0] pmask);
        int done;
        done = 0;
        for (int k = 1; k < 200; k++) begin
            if (done == ACTIVE_CYC) return k;
            if (!(k < 64 && pmask[k])) done++;
        end
        return -1;
    endfunction

    task automatic do_op(input logic [2*N-1:0] x, input logic [2*N-1:0] y,
                         input logic [63:0] pmask, input int ready_low, input bit noise,
                         output logic [2*(N+1)-1:0] res, output int lat,
                         output int en_cnt, output bit hold_ok);
        logic [1:0] px;
        logic [1:0] py;
        bit prev_paused;
        lat = -1; en_cnt = 0; hold_ok = 1'b1; prev_paused = 1'b0;
        px = '0; py = '0; res = '0;
        @(posedge clk); #1;
        x_word = x; y_word = y; start = 1'b1; pause = 1'b0; res_ready = 1'b0;
        for (int k = 1; k < 200; k++) begin
            @(posedge clk); #1;
            start = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                x_word = rand_word();
                y_word = rand_word();
            end
            pause = (k < 64) ? pmask[k] : 1'b0;
            #1;
            if (res_valid) begin
                lat = k;
                break;
            end
            if (add_en) en_cnt++;
            if (prev_paused && (add_x !== px || add_y !== py)) hold_ok = 1'b0;
            prev_paused = pause;
            px = add_x;
            py = add_y;
        end
        if (lat < 0) return;
        res = res_word;
        for (int j = 0; j < ready_low; j++) begin
            @(posedge clk); #1;
            start = noise ? 1'($urandom) : 1'b0;
            pause = noise ? 1'($urandom) : 1'b0;
            res_ready = 1'b0;
            #1;
            if (!res_valid || res_word !== res) hold_ok = 1'b0;
        end
        @(posedge clk); #1;
        start = noise; res_ready = 1'b1;
        #1;
        if (!res_valid || res_word !== res) hold_ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b0; pause = 1'b0;
        #1;
        if (res_valid || busy) hold_ok = 1'b0;
        @(posedge clk); #2;
        if (busy || res_valid) hold_ok = 1'b0;
    endtask

    typedef struct {
        string          name;
        logic [2*N-1:0] x;
        logic [2*N-1:0] y;
        int             exp_val;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [2*(N+1)-1:0] res;
        int lat;
        int en_cnt;
        bit hold_ok;
        logic [63:0] pmask;
        logic [2*N-1:0] rx;
        logic [2*N-1:0] ry;

        // values scaled by 2^N = 256
        vecs[0] = '{"half_plus_quarter", 16'h8000, 16'h2000, 192};
        vecs[1] = '{"all_plus",          16'hAAAA, 16'hAAAA, 510};
        vecs[2] = '{"half_minus_half",   16'h8000, 16'h4000, 0};
        vecs[3] = '{"neg_max_plus_lsb",  16'h5555, 16'h0002, -254};

        rst_n = 1'b0; start = 1'b0; pause = 1'b0; res_ready = 1'b0;
        x_word = '0; y_word = '0;
        #3;
        check("reset_busy", busy, 0);
        check("reset_add_en", add_en, 0);
        check("reset_add_xy", {add_x, add_y}, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_word", res_word, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            do_op(vecs[v].x, vecs[v].y, 64'd0, 0, 1'b0, res, lat, en_cnt, hold_ok);
            check({vecs[v].name, "_value"}, sd_value(64'(res), N+1), vecs[v].exp_val);
            check({vecs[v].name, "_latency"}, lat, BASE_LAT);
            check({vecs[v].name, "_add_en_cycles"}, en_cnt, ACTIVE_CYC);
            check({vecs[v].name, "_handshake"}, hold_ok, 1);
            if (v == 1) check("all_plus_digit0", res[2*N+1 -: 2], 2);
        end

        // pause 3 cycles in STREAM (cycles 5-7) and 2 in DRAIN (cycles 15-16)
        pmask = '0;
        pmask[5] = 1'b1; pmask[6] = 1'b1; pmask[7] = 1'b1;
        pmask[15] = 1'b1; pmask[16] = 1'b1;
        do_op(16'h8000, 16'h2000, pmask, 0, 1'b0, res, lat, en_cnt, hold_ok);
        check("pause_value", sd_value(64'(res), N+1), 192);
        check("pause_latency", lat, BASE_LAT + 5);
        check("pause_add_en_cycles", en_cnt, ACTIVE_CYC);
        check("pause_hold_digits", hold_ok, 1);

        // result held with res_ready low 4 cycles, start pulses while busy
        do_op(16'hAAAA, 16'h5555, 64'd0, 4, 1'b1, res, lat, en_cnt, hold_ok);
        check("ready_low_value", sd_value(64'(res), N+1), 0);
        check("ready_low_latency", lat, BASE_LAT);
        check("ready_low_stable", hold_ok, 1);

        // reset asserted for one cycle in the middle of STREAM
        @(posedge clk); #1;
        x_word = 16'hAAAA; y_word = 16'hAAAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midop_busy_before", busy, 1);
        check("midop_add_en_before", add_en, 1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", busy, 0);
        check("midop_reset_add_en", add_en, 0);
        check("midop_reset_res_valid", res_valid, 0);
        check("midop_reset_res_word", res_word, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(16'h8000, 16'h2000, 64'd0, 0, 1'b0, res, lat, en_cnt, hold_ok);
        check("after_reset_value", sd_value(64'(res), N+1), 192);
        check("after_reset_latency", lat, BASE_LAT);

        // randomized operands, pauses, back-pressure and start noise
        for (int r = 0; r < 20; r++) begin
            rx = rand_word();
            ry = rand_word();
            pmask = '0;
            for (int k = 1; k < 24; k++) pmask[k] = ($urandom_range(0, 3) == 0);
            do_op(rx, ry, pmask, int'($urandom_range(0, 3)), 1'b1, res, lat, en_cnt, hold_ok);
            check("rand_value", sd_value(64'(res), N+1), ref_sum(rx, ry));
            check("rand_latency", lat, ref_lat(pmask));
            check("rand_add_en_cycles", en_cnt, ACTIVE_CYC);
            check("rand_handshake", hold_ok, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
